// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory port (slave).
// Signal names keep their original _o/_i suffixes, as seen from the LSU side.
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    data_req_o;
  logic                    data_gnt_i;
  logic                    data_rvalid_i;
  logic [ADDR_WIDTH-1:0]   data_addr_o;
  logic                    data_we_o;
  logic [DATA_WIDTH/8-1:0] data_be_o;
  logic [DATA_WIDTH-1:0]   data_wdata_o;
  logic [DATA_WIDTH-1:0]   data_rdata_i;

  modport master (
    output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: MEM stage to data memory, req/gnt/rvalid with one
// outstanding access. Byte/half/word/double accesses, byte enables,
// store-data lane replication, signed/unsigned load extension.
// Optional macro LSU_RDATA_REG_EN registers the load result and completion pulse.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  load_store_unit_if.master     bus,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [1:0]            lsu_type_i,
  input  logic                  lsu_sign_ext_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_rvalid_o,
  output logic                  lsu_busy_o,
  output logic                  lsu_err_o
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFS = $clog2(NB);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic                  we_q;
  logic [NB-1:0]         be_q, be_n;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
  logic [OFFS-1:0]       off_q, off_n;
  logic [1:0]            type_q;
  logic                  sign_q;
  logic                  misaligned, accept, req, err, done;
  logic [DATA_WIDTH-1:0] rdata_sh, rdata_ext;

  // Decode the incoming request: aligned address, byte enables, replicated store data, legality.
  always_comb begin
    off_n  = lsu_addr_i[OFFS-1:0];
    addr_n = lsu_addr_i;
    addr_n[OFFS-1:0] = '0;
    be_n       = '1;
    misaligned = 1'b0;
    wdata_n    = '0;
    case (lsu_type_i)
      2'b00: be_n = NB'(1)  << off_n;
      2'b01: be_n = NB'(3)  << off_n;
      2'b10: be_n = NB'(15) << off_n;
      default: be_n = '1;
    endcase
    case (lsu_type_i)
      2'b00: misaligned = 1'b0;
      2'b01: misaligned = lsu_addr_i[0];
      2'b10: misaligned = |lsu_addr_i[1:0];
      default: misaligned = (DATA_WIDTH == 32) || (|lsu_addr_i[2:0]);
    endcase
    for (int unsigned i = 0; i < NB; i++) begin
      case (lsu_type_i)
        2'b00: wdata_n[8*i +: 8] = lsu_wdata_i[7:0];
        2'b01: wdata_n[8*i +: 8] = lsu_wdata_i[8*(i%2) +: 8];
        2'b10: wdata_n[8*i +: 8] = lsu_wdata_i[8*(i%4) +: 8];
        default: wdata_n[8*i +: 8] = lsu_wdata_i[8*i +: 8];
      endcase
    end
  end

  // Align the returned word to the accessed byte and zero/sign-extend it by access size.
  always_comb begin
    logic          msb;
    int unsigned   nbits;
    rdata_sh  = bus.data_rdata_i >> {off_q, 3'b000};
    rdata_ext = '0;
    case (type_q)
      2'b00: begin nbits = 8;  msb = rdata_sh[7];  end
      2'b01: begin nbits = 16; msb = rdata_sh[15]; end
      2'b10: begin nbits = 32; msb = rdata_sh[31]; end
      default: begin nbits = DATA_WIDTH; msb = rdata_sh[DATA_WIDTH-1]; end
    endcase
    for (int unsigned i = 0; i < DATA_WIDTH; i++)
      rdata_ext[i] = (i < nbits) ? rdata_sh[i] : (sign_q & msb);
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    req     = 1'b0;
    err     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (lsu_req_i && !rst_i) begin
          if (misaligned) begin
            err = 1'b1;
          end else begin
            accept  = 1'b1;
            req     = 1'b1;
            state_d = bus.data_gnt_i ? WAIT_RVALID : WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        req = 1'b1;
        if (bus.data_gnt_i) state_d = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (bus.data_rvalid_i) begin
          done = 1'b1;
`ifdef LSU_RDATA_REG_EN
          state_d = RESP;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Capture the decoded access on acceptance; held stable until the access completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      type_q  <= '0;
      sign_q  <= 1'b0;
    end else if (accept) begin
      addr_q  <= addr_n;
      we_q    <= lsu_we_i;
      be_q    <= be_n;
      wdata_q <= wdata_n;
      off_q   <= off_n;
      type_q  <= lsu_type_i;
      sign_q  <= lsu_sign_ext_i;
    end
  end

  // In the acceptance cycle the bus sees the live decode; afterwards the captured copy.
  assign bus.data_req_o   = req;
  assign bus.data_addr_o  = accept ? addr_n   : addr_q;
  assign bus.data_we_o    = accept ? lsu_we_i : we_q;
  assign bus.data_be_o    = accept ? be_n     : be_q;
  assign bus.data_wdata_o = accept ? wdata_n  : wdata_q;

  assign lsu_busy_o = (state_q != IDLE);
  assign lsu_err_o  = err;

`ifdef LSU_RDATA_REG_EN
  logic [DATA_WIDTH-1:0] rdata_q;

  // Register the extended load result; the completion pulse is the RESP state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (done) rdata_q <= rdata_ext;
  end

  assign lsu_rdata_o  = rdata_q;
  assign lsu_rvalid_o = (state_q == RESP);
`else
  assign lsu_rdata_o  = done ? rdata_ext : '0;
  assign lsu_rvalid_o = done;
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (DATA_WIDTH=32). Inputs change on the
// falling edge, outputs are checked 1 ns later. Handles both the combinational
// and the LSU_RDATA_REG_EN response paths.
module tb_load_store_unit;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          lsu_req, lsu_we, lsu_sign;
  logic [1:0]    lsu_type;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic          lsu_rvalid, lsu_busy, lsu_err;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  load_store_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem ();

  load_store_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (mem),
    .lsu_req_i      (lsu_req),
    .lsu_we_i       (lsu_we),
    .lsu_type_i     (lsu_type),
    .lsu_sign_ext_i (lsu_sign),
    .lsu_addr_i     (lsu_addr),
    .lsu_wdata_i    (lsu_wdata),
    .lsu_rdata_o    (lsu_rdata),
    .lsu_rvalid_o   (lsu_rvalid),
    .lsu_busy_o     (lsu_busy),
    .lsu_err_o      (lsu_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present a request in IDLE (optionally granted in the same cycle).
  task automatic issue(input logic we, input logic [1:0] typ, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd, input logic gnt);
    @(negedge clk);
    lsu_req = 1'b1; lsu_we = we; lsu_type = typ; lsu_sign = sgn;
    lsu_addr = addr; lsu_wdata = wd;
    mem.data_gnt_i = gnt;
    #1;
  endtask

  // Respond in WAIT_RVALID and check the completion pulse (and data for loads).
  task automatic resp(input string tag, input logic [31:0] rd, input logic [31:0] exp,
                      input logic chk_data);
    @(negedge clk);
    lsu_req = 1'b0; mem.data_gnt_i = 1'b0;
    mem.data_rvalid_i = 1'b1; mem.data_rdata_i = rd;
    #1;
    chk({tag, "_busy"}, lsu_busy, 1);
    chk({tag, "_req_low"}, mem.data_req_o, 0);
`ifdef LSU_RDATA_REG_EN
    chk({tag, "_rvalid_early"}, lsu_rvalid, 0);
    @(negedge clk);
    mem.data_rvalid_i = 1'b0;
    #1;
    chk({tag, "_busy_resp"}, lsu_busy, 1);
`endif
    chk({tag, "_rvalid"}, lsu_rvalid, 1);
    if (chk_data) chk({tag, "_rdata"}, lsu_rdata, exp);
    @(negedge clk);
    mem.data_rvalid_i = 1'b0;
    #1;
    chk({tag, "_rvalid_end"}, lsu_rvalid, 0);
    chk({tag, "_idle"}, lsu_busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_type = 2'b00; lsu_sign = 1'b0;
    lsu_addr = '0; lsu_wdata = '0;
    mem.data_gnt_i = 1'b0; mem.data_rvalid_i = 1'b0; mem.data_rdata_i = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",    mem.data_req_o,   0);
    chk("rst_we",     mem.data_we_o,    0);
    chk("rst_be",     mem.data_be_o,    0);
    chk("rst_addr",   mem.data_addr_o,  0);
    chk("rst_wdata",  mem.data_wdata_o, 0);
    chk("rst_rvalid", lsu_rvalid,       0);
    chk("rst_busy",   lsu_busy,         0);
    chk("rst_err",    lsu_err,          0);
    chk("rst_rdata",  lsu_rdata,        0);
    rst = 1'b0;

    // Signed byte load at offset 2.
    issue(0, 2'b00, 1, 32'h0000_1002, 32'h0, 1);
    chk("lbs_req",  mem.data_req_o,  1);
    chk("lbs_addr", mem.data_addr_o, 32'h0000_1000);
    chk("lbs_be",   mem.data_be_o,   4'b0100);
    chk("lbs_we",   mem.data_we_o,   0);
    chk("lbs_busy", lsu_busy,        0);
    resp("lbs", 32'h80FF_1234, 32'hFFFF_FFFF, 1);

    // Same byte, unsigned; accepted right after the previous completion.
    issue(0, 2'b00, 0, 32'h0000_1002, 32'h0, 1);
    chk("lbu_be", mem.data_be_o, 4'b0100);
    resp("lbu", 32'h80FF_1234, 32'h0000_00FF, 1);

    // Halfword store at offset 2.
    issue(1, 2'b01, 0, 32'h0000_1002, 32'h0000_ABCD, 1);
    chk("sh_be",    mem.data_be_o,    4'b1100);
    chk("sh_wdata", mem.data_wdata_o, 32'hABCD_ABCD);
    chk("sh_we",    mem.data_we_o,    1);
    chk("sh_addr",  mem.data_addr_o,  32'h0000_1000);
    resp("sh", 32'h0, 32'h0, 0);

    // Byte store at offset 3.
    issue(1, 2'b00, 0, 32'h0000_0013, 32'h1234_565A, 1);
    chk("sb_be",    mem.data_be_o,    4'b1000);
    chk("sb_wdata", mem.data_wdata_o, 32'h5A5A_5A5A);
    chk("sb_addr",  mem.data_addr_o,  32'h0000_0010);
    resp("sb", 32'h0, 32'h0, 0);

    // Word store replicates nothing but must pass through unchanged.
    issue(1, 2'b10, 0, 32'h0000_0020, 32'hCAFE_F00D, 1);
    chk("sw_be",    mem.data_be_o,    4'b1111);
    chk("sw_wdata", mem.data_wdata_o, 32'hCAFE_F00D);
    resp("sw", 32'h0, 32'h0, 0);

    // Halfword loads: signed upper half, unsigned lower half.
    issue(0, 2'b01, 1, 32'h0000_3002, 32'h0, 1);
    chk("lhs_be", mem.data_be_o, 4'b1100);
    resp("lhs", 32'h8001_7FFF, 32'hFFFF_8001, 1);
    issue(0, 2'b01, 0, 32'h0000_3000, 32'h0, 1);
    chk("lhu_be", mem.data_be_o, 4'b0011);
    resp("lhu", 32'h1234_F00D, 32'h0000_F00D, 1);

    // Signed byte load at offset 1.
    issue(0, 2'b00, 1, 32'h0000_0101, 32'h0, 1);
    chk("lb1_be", mem.data_be_o, 4'b0010);
    resp("lb1", 32'h0000_A500, 32'hFFFF_FFA5, 1);

    // Word load with grant delayed 3 cycles; request inputs toggle while busy.
    issue(0, 2'b10, 0, 32'h0000_2004, 32'hFFFF_FFFF, 0);
    chk("dly_req0",  mem.data_req_o,  1);
    chk("dly_addr0", mem.data_addr_o, 32'h0000_2004);
    chk("dly_be0",   mem.data_be_o,   4'b1111);
    chk("dly_busy0", lsu_busy,        0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      lsu_req = 1'b1; lsu_we = 1'b1; lsu_type = 2'b00; lsu_addr = 32'h0000_5557;
      mem.data_rvalid_i = (c == 2);
      mem.data_rdata_i  = 32'h1111_1111;
      mem.data_gnt_i    = (c == 3);
      #1;
      chk("dly_req",    mem.data_req_o,  1);
      chk("dly_addr",   mem.data_addr_o, 32'h0000_2004);
      chk("dly_be",     mem.data_be_o,   4'b1111);
      chk("dly_we",     mem.data_we_o,   0);
      chk("dly_busy",   lsu_busy,        1);
      chk("dly_rvalid", lsu_rvalid,      0);
    end
    @(negedge clk);
    mem.data_gnt_i = 1'b0; mem.data_rvalid_i = 1'b0;
    #1;
    chk("dly_wait_req",    mem.data_req_o, 0);
    chk("dly_wait_busy",   lsu_busy,       1);
    chk("dly_wait_rvalid", lsu_rvalid,     0);
    resp("dly", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);

    // Rejected accesses.
    @(negedge clk);
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_type = 2'b10; lsu_addr = 32'h0000_1001;
    #1;
    chk("errw_err",  lsu_err,        1);
    chk("errw_req",  mem.data_req_o, 0);
    chk("errw_busy", lsu_busy,       0);
    @(negedge clk);
    lsu_type = 2'b11; lsu_addr = 32'h0000_1000;
    #1;
    chk("errd_err",  lsu_err,        1);
    chk("errd_req",  mem.data_req_o, 0);
    chk("errd_busy", lsu_busy,       0);
    @(negedge clk);
    lsu_type = 2'b01; lsu_addr = 32'h0000_1003;
    #1;
    chk("errh_err", lsu_err,        1);
    chk("errh_req", mem.data_req_o, 0);
    @(negedge clk);
    lsu_req = 1'b0;
    #1;
    chk("err_clear", lsu_err,  0);
    chk("err_idle",  lsu_busy, 0);

    // Reset in WAIT_GNT drops the request without a clock edge.
    issue(0, 2'b10, 0, 32'h0000_4000, 32'h0, 0);
    @(negedge clk);
    lsu_req = 1'b0;
    #1;
    chk("rg_busy", lsu_busy,       1);
    chk("rg_req",  mem.data_req_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("rg_req_async",  mem.data_req_o,  0);
    chk("rg_busy_async", lsu_busy,        0);
    chk("rg_addr_async", mem.data_addr_o, 0);
    chk("rg_be_async",   mem.data_be_o,   0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in WAIT_RVALID, then a stray response is ignored.
    issue(0, 2'b10, 0, 32'h0000_4000, 32'h0, 1);
    @(negedge clk);
    lsu_req = 1'b0; mem.data_gnt_i = 1'b0;
    #1;
    chk("rr_busy", lsu_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rr_busy_async", lsu_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    mem.data_rvalid_i = 1'b1; mem.data_rdata_i = 32'h0000_0001;
    #1;
    chk("rr_stray_rvalid", lsu_rvalid, 0);
    @(negedge clk);
    mem.data_rvalid_i = 1'b0;
    #1;
    chk("rr_stray_rvalid2", lsu_rvalid, 0);
    chk("rr_idle",          lsu_busy,   0);

    // Normal operation resumes after the reset.
    issue(0, 2'b10, 1, 32'h0000_0040, 32'h0, 1);
    chk("post_addr", mem.data_addr_o, 32'h0000_0040);
    resp("post", 32'h8000_0001, 32'h8000_0001, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
